// File: rtl/mac_kbd_host_if.sv
// Command/response handshake between the Mac-side caller and the keyboard host.
interface mac_kbd_host_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] resp_data;
    logic       resp_valid;
    logic       resp_timeout;

    // Caller side: issues commands, receives responses
    modport master (
        output cmd_data,
        output cmd_valid,
        input  cmd_ready,
        input  resp_data,
        input  resp_valid,
        input  resp_timeout
    );

    // Host side: accepts commands, reports responses
    modport slave (
        input  cmd_data,
        input  cmd_valid,
        output cmd_ready,
        output resp_data,
        output resp_valid,
        output resp_timeout
    );
endinterface

// File: rtl/mac_kbd_host.sv
// Macintosh-side initiator for the 128K/512K/Plus keyboard serial link.
// Sends one command byte on keyboard-generated clocks, then receives one response byte.
module mac_kbd_host #(
    parameter int unsigned START_TICKS = 2437500,
    parameter int unsigned BIT_TICKS   = 8125,
    parameter int unsigned TURN_TICKS  = 800
) (
    input  logic          clk32,
    input  logic          _reset,
    input  logic          clk8_en_p,
    input  logic          kbd_clk_i,
    input  logic          kbd_dat_i,
    output logic          kbd_dat_oe,
    output logic          busy,
    mac_kbd_host_if.slave host
);

    localparam int unsigned TW = 22;
    localparam int unsigned CW = 4;
    localparam logic [TW-1:0] START_LIM = TW'(START_TICKS - 1);
    localparam logic [TW-1:0] BIT_LIM   = TW'(BIT_TICKS - 1);
    localparam logic [TW-1:0] TURN_LIM  = TW'(TURN_TICKS - 1);
    localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_TX,
        S_TURN,
        S_RXW,
        S_RX,
        S_ABORT
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [CW-1:0] bitcnt_q, bitcnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          oe_q, oe_d;
    logic [7:0]    resp_data_q, resp_data_d;
    logic          resp_valid_q, resp_valid_d;
    logic          resp_timeout_q, resp_timeout_d;
    logic          busy_q, busy_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          clk_s1_q, clk_s1_d;
    logic          clk_s2_q, clk_s2_d;
    logic          clk_prev_q, clk_prev_d;
    logic          dat_s1_q, dat_s1_d;
    logic          dat_s2_q, dat_s2_d;

    logic          clk_rise;
    logic          clk_fall;
    logic          clk_edge;
    logic          go_abort;
    logic [7:0]    rx_byte;

    // Edge events from the synchronised CLK versus its previous sample
    assign clk_rise = ~clk_prev_q & clk_s2_q;
    assign clk_fall = clk_prev_q & ~clk_s2_q;
    assign clk_edge = clk_rise | clk_fall;
    assign rx_byte  = {shift_q[6:0], dat_s2_q};

    // Next-state, datapath and output computation; everything advances only on clk8_en_p
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bitcnt_d       = bitcnt_q;
        timer_d        = timer_q;
        oe_d           = oe_q;
        resp_data_d    = resp_data_q;
        resp_valid_d   = resp_valid_q;
        resp_timeout_d = resp_timeout_q;
        busy_d         = busy_q;
        cmd_ready_d    = cmd_ready_q;
        clk_s1_d       = clk_s1_q;
        clk_s2_d       = clk_s2_q;
        clk_prev_d     = clk_prev_q;
        dat_s1_d       = dat_s1_q;
        dat_s2_d       = dat_s2_q;
        go_abort       = 1'b0;

        if (clk8_en_p) begin
            clk_s1_d       = kbd_clk_i;
            clk_s2_d       = clk_s1_q;
            clk_prev_d     = clk_s2_q;
            dat_s1_d       = kbd_dat_i;
            dat_s2_d       = dat_s1_q;
            resp_valid_d   = 1'b0;
            resp_timeout_d = 1'b0;
            timer_d        = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);

            // Any CLK edge while the keyboard is clocking restarts the gap timer
            if (clk_edge && (state_q inside {S_REQ, S_TX, S_RXW, S_RX})) begin
                timer_d = '0;
            end

            case (state_q)
                S_IDLE: begin
                    oe_d    = 1'b0;
                    timer_d = '0;
                    if (host.cmd_valid && cmd_ready_q) begin
                        shift_d  = host.cmd_data;
                        bitcnt_d = '0;
                        oe_d     = 1'b1;
                        state_d  = S_REQ;
                    end
                end
                S_REQ: begin
                    if (clk_fall) begin
                        oe_d    = ~shift_q[7];
                        state_d = S_TX;
                    end else if (!clk_edge && timer_q >= START_LIM) begin
                        go_abort = 1'b1;
                    end
                end
                S_TX: begin
                    if (clk_rise) begin
                        bitcnt_d = bitcnt_q + CW'(1);
                        shift_d  = {shift_q[6:0], 1'b0};
                        if (bitcnt_q == CW'(7)) begin
                            oe_d    = 1'b1;
                            timer_d = '0;
                            state_d = S_TURN;
                        end
                    end else if (clk_fall) begin
                        if (bitcnt_q < CW'(8)) begin
                            oe_d = ~shift_q[7];
                        end
                    end else if (timer_q >= BIT_LIM) begin
                        go_abort = 1'b1;
                    end
                end
                S_TURN: begin
                    if (timer_q >= TURN_LIM) begin
                        oe_d     = 1'b0;
                        bitcnt_d = '0;
                        timer_d  = '0;
                        state_d  = S_RXW;
                    end
                end
                S_RXW: begin
                    if (clk_fall) begin
                        state_d = S_RX;
                    end else if (!clk_edge && timer_q >= START_LIM) begin
                        go_abort = 1'b1;
                    end
                end
                S_RX: begin
                    if (clk_rise) begin
                        shift_d  = rx_byte;
                        bitcnt_d = bitcnt_q + CW'(1);
                        if (bitcnt_q == CW'(7)) begin
                            resp_data_d  = rx_byte;
                            resp_valid_d = 1'b1;
                            state_d      = S_IDLE;
                        end
                    end else if (!clk_fall && timer_q >= BIT_LIM) begin
                        go_abort = 1'b1;
                    end
                end
                S_ABORT: begin
                    oe_d    = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    oe_d    = 1'b0;
                    state_d = S_IDLE;
                end
            endcase

            // Abandon the transaction: release DATA and flag the timeout for one tick
            if (go_abort) begin
                oe_d           = 1'b0;
                timer_d        = '0;
                resp_timeout_d = 1'b1;
                state_d        = S_ABORT;
            end

            busy_d      = (state_d != S_IDLE);
            cmd_ready_d = (state_d == S_IDLE);
        end
    end

    // State and output registers; reset releases DATA immediately
    always_ff @(posedge clk32 or negedge _reset) begin
        if (!_reset) begin
            state_q        <= S_IDLE;
            shift_q        <= '0;
            bitcnt_q       <= '0;
            timer_q        <= '0;
            oe_q           <= 1'b0;
            resp_data_q    <= '0;
            resp_valid_q   <= 1'b0;
            resp_timeout_q <= 1'b0;
            busy_q         <= 1'b0;
            cmd_ready_q    <= 1'b1;
            clk_s1_q       <= 1'b1;
            clk_s2_q       <= 1'b1;
            clk_prev_q     <= 1'b1;
            dat_s1_q       <= 1'b1;
            dat_s2_q       <= 1'b1;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bitcnt_q       <= bitcnt_d;
            timer_q        <= timer_d;
            oe_q           <= oe_d;
            resp_data_q    <= resp_data_d;
            resp_valid_q   <= resp_valid_d;
            resp_timeout_q <= resp_timeout_d;
            busy_q         <= busy_d;
            cmd_ready_q    <= cmd_ready_d;
            clk_s1_q       <= clk_s1_d;
            clk_s2_q       <= clk_s2_d;
            clk_prev_q     <= clk_prev_d;
            dat_s1_q       <= dat_s1_d;
            dat_s2_q       <= dat_s2_d;
        end
    end

    assign kbd_dat_oe        = oe_q;
    assign busy              = busy_q;
    assign host.cmd_ready    = cmd_ready_q;
    assign host.resp_data    = resp_data_q;
    assign host.resp_valid   = resp_valid_q;
    assign host.resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_mac_kbd_host.sv
// Directed bench for mac_kbd_host with a scaled-down keyboard model.
module tb_mac_kbd_host;

    localparam int unsigned ST = 400;
    localparam int unsigned BT = 60;
    localparam int unsigned TT = 8;

    logic clk32 = 1'b0;
    logic _reset;
    logic clk8_en_p;
    logic kbd_clk_i;
    logic kbd_dat_i;
    logic kbd_dat_oe;
    logic busy;
    logic kb_low;

    int checks   = 0;
    int failures = 0;
    int rv_cnt   = 0;
    int to_cnt   = 0;
    int oe_cnt   = 0;
    logic rdy_at_rv = 1'b0;

    mac_kbd_host_if bus();

    mac_kbd_host #(
        .START_TICKS(ST),
        .BIT_TICKS  (BT),
        .TURN_TICKS (TT)
    ) dut (
        .clk32     (clk32),
        ._reset    (_reset),
        .clk8_en_p (clk8_en_p),
        .kbd_clk_i (kbd_clk_i),
        .kbd_dat_i (kbd_dat_i),
        .kbd_dat_oe(kbd_dat_oe),
        .busy      (busy),
        .host      (bus)
    );

    // Open-drain DATA line: low if either end pulls it
    assign kbd_dat_i = ~(kbd_dat_oe | kb_low);

    always #5 clk32 = ~clk32;

    // One enable every fourth clk32 cycle, changed just after the rising edge
    initial begin
        int cnt;
        cnt = 0;
        clk8_en_p = 1'b0;
        forever begin
            @(posedge clk32);
            #1;
            cnt = (cnt + 1) % 4;
            clk8_en_p = (cnt == 0);
        end
    end

    // Pulse counters observed on enabled edges
    always @(posedge clk32) begin
        if (clk8_en_p) begin
            if (bus.resp_valid) begin
                rv_cnt = rv_cnt + 1;
                rdy_at_rv = bus.cmd_ready;
            end
            if (bus.resp_timeout) to_cnt = to_cnt + 1;
            if (kbd_dat_oe) oe_cnt = oe_cnt + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (4 * n) @(negedge clk32);
    endtask

    task automatic issue_cmd(input logic [7:0] c, output bit ok);
        ok = 1'b0;
        @(negedge clk32);
        bus.cmd_data  = c;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (clk8_en_p && bus.cmd_ready) ok = 1'b1;
            else @(negedge clk32);
        end
        @(posedge clk32);
        @(negedge clk32);
        bus.cmd_valid = 1'b0;
    endtask

    // Keyboard: clock the command in, wait for release, clock nresp response bits out
    task automatic kb_xact(input logic [7:0] resp, input int nresp,
                           output logic [7:0] got, output bit ok);
        int n;
        ok  = 1'b1;
        got = 8'h00;
        n   = 0;
        while (!kbd_dat_oe && n < 400) begin n++; @(negedge clk32); end
        if (!kbd_dat_oe) ok = 1'b0;
        wait_ticks(5);
        for (int i = 0; i < 8; i++) begin
            kbd_clk_i = 1'b0;
            wait_ticks(8);
            got = {got[6:0], kbd_dat_i};
            kbd_clk_i = 1'b1;
            wait_ticks(8);
        end
        n = 0;
        while (kbd_dat_oe && n < 400) begin n++; @(negedge clk32); end
        if (kbd_dat_oe) ok = 1'b0;
        wait_ticks(3);
        for (int i = 0; i < nresp; i++) begin
            kb_low = ~resp[7 - i];
            wait_ticks(2);
            kbd_clk_i = 1'b0;
            wait_ticks(8);
            kbd_clk_i = 1'b1;
            if (i < nresp - 1) wait_ticks(8);
        end
        wait_ticks(4);
        kb_low = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (kbd_dat_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", kbd_dat_oe); end
        checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (bus.resp_data !== 8'h00) begin failures++; $display("FAIL reset_resp_data got=%h exp=00", bus.resp_data); end
        checks++; if ({bus.resp_valid, bus.resp_timeout} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {bus.resp_valid, bus.resp_timeout}); end
    endtask

    task automatic test_inquiry();
        bit ok, ok2;
        logic [7:0] got;
        int rv0, to0;
        rv0 = rv_cnt; to0 = to_cnt;
        issue_cmd(8'h10, ok);
        checks++; if (ok !== 1'b1) begin failures++; $display("FAIL inq_accept got=%b exp=1", ok); end
        kb_xact(8'h7B, 8, got, ok2);
        wait_ticks(10);
        checks++; if (ok2 !== 1'b1) begin failures++; $display("FAIL inq_handshake got=%b exp=1", ok2); end
        checks++; if (got !== 8'h10) begin failures++; $display("FAIL inq_tx_bits got=%h exp=10", got); end
        checks++; if (bus.resp_data !== 8'h7B) begin failures++; $display("FAIL inq_resp got=%h exp=7b", bus.resp_data); end
        checks++; if (rv_cnt - rv0 !== 1) begin failures++; $display("FAIL inq_valid_pulses got=%0d exp=1", rv_cnt - rv0); end
        checks++; if (to_cnt - to0 !== 0) begin failures++; $display("FAIL inq_timeouts got=%0d exp=0", to_cnt - to0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL inq_busy got=%b exp=0", busy); end
    endtask

    task automatic test_start_timeout();
        bit ok;
        int n, rv0, to0;
        rv0 = rv_cnt; to0 = to_cnt;
        issue_cmd(8'h36, ok);
        n = 0;
        while (kbd_dat_oe && n < 4 * ST + 100) begin n++; @(negedge clk32); end
        wait_ticks(5);
        checks++; if (n !== 4 * ST) begin failures++; $display("FAIL start_oe_cycles got=%0d exp=%0d", n, 4 * ST); end
        checks++; if (to_cnt - to0 !== 1) begin failures++; $display("FAIL start_timeout_pulses got=%0d exp=1", to_cnt - to0); end
        checks++; if (rv_cnt - rv0 !== 0) begin failures++; $display("FAIL start_valid got=%0d exp=0", rv_cnt - rv0); end
        checks++; if ({kbd_dat_oe, busy} !== 2'b00) begin failures++; $display("FAIL start_idle got=%b exp=00", {kbd_dat_oe, busy}); end
    endtask

    task automatic test_bit_timeout();
        bit ok, ok2;
        logic [7:0] got;
        int n, rv0, to0;
        rv0 = rv_cnt; to0 = to_cnt;
        issue_cmd(8'h14, ok);
        kb_xact(8'hA0, 4, got, ok2);
        n = 0;
        while (!bus.resp_timeout && n < BT + 50) begin
            @(posedge clk32);
            if (clk8_en_p) n++;
            @(negedge clk32);
        end
        n = n + 4;
        wait_ticks(3);
        checks++; if (got !== 8'h14) begin failures++; $display("FAIL bit_tx_bits got=%h exp=14", got); end
        checks++; if (n < BT || n > BT + 3) begin failures++; $display("FAIL bit_timeout_delay got=%0d exp=%0d..%0d", n, BT, BT + 3); end
        checks++; if (to_cnt - to0 !== 1) begin failures++; $display("FAIL bit_timeout_pulses got=%0d exp=1", to_cnt - to0); end
        checks++; if (bus.resp_data !== 8'h7B) begin failures++; $display("FAIL bit_resp_kept got=%h exp=7b", bus.resp_data); end
        checks++; if (rv_cnt - rv0 !== 0) begin failures++; $display("FAIL bit_valid got=%0d exp=0", rv_cnt - rv0); end
    endtask

    task automatic test_back_to_back();
        bit ok, ok2, ok3;
        logic [7:0] got, got2;
        int rv0;
        logic rdy_mid, busy_mid;
        rv0 = rv_cnt;
        rdy_mid = 1'b1; busy_mid = 1'b0;
        issue_cmd(8'h16, ok);
        fork
            kb_xact(8'h55, 8, got, ok2);
            begin
                wait_ticks(40);
                @(negedge clk32);
                bus.cmd_data  = 8'h36;
                bus.cmd_valid = 1'b1;
                wait_ticks(2);
                rdy_mid  = bus.cmd_ready;
                busy_mid = busy;
            end
        join
        wait_ticks(2);
        checks++; if (rdy_mid !== 1'b0 || busy_mid !== 1'b1) begin failures++; $display("FAIL b2b_busy_tx got=%b%b exp=01", rdy_mid, busy_mid); end
        checks++; if (got !== 8'h16) begin failures++; $display("FAIL b2b_tx_bits got=%h exp=16", got); end
        checks++; if (bus.resp_data !== 8'h55) begin failures++; $display("FAIL b2b_resp1 got=%h exp=55", bus.resp_data); end
        checks++; if (rv_cnt - rv0 !== 1) begin failures++; $display("FAIL b2b_valid1 got=%0d exp=1", rv_cnt - rv0); end
        checks++; if (rdy_at_rv !== 1'b1) begin failures++; $display("FAIL b2b_ready_at_valid got=%b exp=1", rdy_at_rv); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_second_accept got=%b exp=1", busy); end
        @(negedge clk32);
        bus.cmd_valid = 1'b0;
        kb_xact(8'hC3, 8, got2, ok3);
        wait_ticks(4);
        checks++; if (got2 !== 8'h36) begin failures++; $display("FAIL b2b_tx2_bits got=%h exp=36", got2); end
        checks++; if (bus.resp_data !== 8'hC3) begin failures++; $display("FAIL b2b_resp2 got=%h exp=c3", bus.resp_data); end
    endtask

    task automatic test_reset_mid_tx();
        bit ok, ok2;
        logic [7:0] got;
        int rv0;
        issue_cmd(8'h16, ok);
        wait_ticks(5);
        for (int i = 0; i < 2; i++) begin
            kbd_clk_i = 1'b0; wait_ticks(8);
            kbd_clk_i = 1'b1; wait_ticks(8);
        end
        kbd_clk_i = 1'b0;
        wait_ticks(6);
        checks++; if (kbd_dat_oe !== 1'b1) begin failures++; $display("FAIL rst_pre_oe got=%b exp=1", kbd_dat_oe); end
        #3;
        _reset = 1'b0;
        #1;
        checks++; if (kbd_dat_oe !== 1'b0) begin failures++; $display("FAIL rst_async_oe got=%b exp=0", kbd_dat_oe); end
        checks++; if ({busy, bus.cmd_ready, bus.resp_valid, bus.resp_timeout} !== 4'b0100) begin failures++; $display("FAIL rst_outputs got=%b exp=0100", {busy, bus.cmd_ready, bus.resp_valid, bus.resp_timeout}); end
        checks++; if (bus.resp_data !== 8'h00) begin failures++; $display("FAIL rst_resp_data got=%h exp=00", bus.resp_data); end
        kbd_clk_i = 1'b1;
        wait_ticks(2);
        @(negedge clk32);
        _reset = 1'b1;
        wait_ticks(4);
        rv0 = rv_cnt;
        issue_cmd(8'h10, ok);
        kb_xact(8'h3C, 8, got, ok2);
        wait_ticks(4);
        checks++; if (got !== 8'h10) begin failures++; $display("FAIL rst_next_tx got=%h exp=10", got); end
        checks++; if (bus.resp_data !== 8'h3C) begin failures++; $display("FAIL rst_next_resp got=%h exp=3c", bus.resp_data); end
        checks++; if (rv_cnt - rv0 !== 1) begin failures++; $display("FAIL rst_next_valid got=%0d exp=1", rv_cnt - rv0); end
    endtask

    task automatic test_idle_noise();
        int rv0, to0, oe0;
        rv0 = rv_cnt; to0 = to_cnt; oe0 = oe_cnt;
        kb_low = 1'b1;
        for (int i = 0; i < 10; i++) begin
            kbd_clk_i = 1'b0; wait_ticks(6);
            kbd_clk_i = 1'b1; wait_ticks(6);
        end
        kb_low = 1'b0;
        wait_ticks(10);
        checks++; if (rv_cnt - rv0 !== 0) begin failures++; $display("FAIL idle_valid got=%0d exp=0", rv_cnt - rv0); end
        checks++; if (to_cnt - to0 !== 0) begin failures++; $display("FAIL idle_timeout got=%0d exp=0", to_cnt - to0); end
        checks++; if (oe_cnt - oe0 !== 0) begin failures++; $display("FAIL idle_oe_ticks got=%0d exp=0", oe_cnt - oe0); end
        checks++; if ({busy, bus.cmd_ready} !== 2'b01) begin failures++; $display("FAIL idle_state got=%b exp=01", {busy, bus.cmd_ready}); end
    endtask

    initial begin
        _reset        = 1'b0;
        kbd_clk_i     = 1'b1;
        kb_low        = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.cmd_valid = 1'b0;
        repeat (10) @(negedge clk32);
        test_reset();
        _reset = 1'b1;
        wait_ticks(4);
        test_inquiry();
        test_start_timeout();
        test_bit_timeout();
        test_back_to_back();
        test_reset_mid_tx();
        test_idle_noise();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
